// File: rtl/cpu_seg_display.sv
// cpu_seg_display
// Shows one of five CPU values on an 8-digit multiplexed 7-segment display.
// The value is shown in hex or in decimal. Decimal uses an iterative
// shift-add-3 (double-dabble) binary-to-BCD converter.
//
// Ports
//   clk                 system clock
//   rst                 asynchronous reset, active low
//   led_data_in         CPU syscall display value
//   total_cycles        CPU cycle counter
//   condi_branch_num    taken conditional branch counter
//   uncondi_branch_num  unconditional jump counter
//   bubble_num          load-use bubble counter
//   disp_sel            source select (0..4 as listed above, 5..7 show 0)
//   hex_mode            1 = hex, 0 = decimal
//   seg                 active-low cathodes, [7]=dp, [6:0]=g..a
//   an                  active-low anodes, bit 0 = rightmost digit
//   conv_busy           high while the converter is shifting
//
// Converter states
//   state   | meaning
//   S_IDLE  | snapshot source and mode, clear BCD accumulator
//   S_SHIFT | 32 add-3/shift steps (decimal only)
//   S_LOAD  | publish the result to the digit register
module cpu_seg_display #(
  parameter int SCAN_DIV = 100000,
  parameter int DIV_BITS = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] led_data_in,
  input  logic [31:0] total_cycles,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] uncondi_branch_num,
  input  logic [31:0] bubble_num,
  input  logic [2:0]  disp_sel,
  input  logic        hex_mode,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        conv_busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD} state_e;

  localparam logic [DIV_BITS-1:0] DIV_TC = DIV_BITS'(SCAN_DIV - 1);

  state_e        state_q, state_d;
  logic [31:0]   snap_q, snap_d;
  logic [39:0]   bcd_q, bcd_d;
  logic [39:0]   bcd_adj;
  logic [4:0]    cnt_q, cnt_d;
  logic          hex_q, hex_d;
  logic [31:0]   digits_q, digits_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   src;

  logic [DIV_BITS-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic [3:0]    nib;
  logic [31:0]   upper;
  logic          blank;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h40;
      4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;
      4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;
      4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;
      4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;
      4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;
      4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;
      4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;
      default: hex_font = 7'h0E;
    endcase
  endfunction

  always_comb begin
    src = 32'h0;
    case (disp_sel)
      3'd0: src = led_data_in;
      3'd1: src = total_cycles;
      3'd2: src = condi_branch_num;
      3'd3: src = uncondi_branch_num;
      3'd4: src = bubble_num;
      default: src = 32'h0;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    hex_d    = hex_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        snap_d  = src;
        bcd_d   = 40'h0;
        cnt_d   = 5'd0;
        hex_d   = hex_mode;
        state_d = hex_mode ? S_LOAD : S_SHIFT;
      end
      S_SHIFT: begin
        // Adjust and shift happen in one step on the concatenated register.
        {bcd_d, snap_d} = {bcd_adj, snap_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (hex_q) begin
          digits_d = snap_q;
          ovf_d    = 1'b0;
        end else begin
          digits_d = bcd_q[31:0];
          ovf_d    = (bcd_q[39:32] != 8'h0);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q + DIV_BITS'(1);
    idx_d = idx_q;
    if (div_q == DIV_TC) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  always_comb begin
    nib   = digits_q[{idx_q, 2'b00} +: 4];
    // Digits at and above the current index, used for leading-zero blanking.
    upper = digits_q >> {idx_q, 2'b00};
    blank = !hex_q && (idx_q != 3'd0) && (upper == 32'h0);
    seg_d = {~((idx_q == 3'd7) && ovf_q), blank ? 7'h7F : hex_font(nib)};
    an_d  = ~(8'b1 << idx_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      snap_q   <= 32'h0;
      bcd_q    <= 40'h0;
      cnt_q    <= 5'd0;
      hex_q    <= 1'b0;
      digits_q <= 32'h0;
      ovf_q    <= 1'b0;
      div_q    <= '0;
      idx_q    <= 3'd0;
      seg_q    <= 8'hFF;
      an_q     <= 8'hFF;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign conv_busy = (state_q == S_SHIFT);

endmodule

// File: tb/tb_cpu_seg_display.sv
module tb_cpu_seg_display;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] led_data_in, total_cycles, condi_branch_num, uncondi_branch_num, bubble_num;
  logic [2:0]  disp_sel;
  logic        hex_mode;
  logic [7:0]  seg, an;
  logic        conv_busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  cpu_seg_display #(.SCAN_DIV(SCAN_DIV), .DIV_BITS(17)) dut (
    .clk(clk), .rst(rst),
    .led_data_in(led_data_in), .total_cycles(total_cycles),
    .condi_branch_num(condi_branch_num), .uncondi_branch_num(uncondi_branch_num),
    .bubble_num(bubble_num), .disp_sel(disp_sel), .hex_mode(hex_mode),
    .seg(seg), .an(an), .conv_busy(conv_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Expected 8-digit frame: byte i is the seg value while digit i is lit.
  function automatic logic [63:0] model(input logic [31:0] v, input logic hex);
    logic [63:0] f;
    longint unsigned rest;
    f = '0;
    if (hex) begin
      for (int i = 0; i < 8; i++) f[8*i +: 8] = {1'b1, glyph(int'((v >> (4*i)) & 32'hF))};
    end else begin
      rest = longint'(v) % 100000000;
      for (int i = 0; i < 8; i++) begin
        if (i != 0 && rest == 0) f[8*i +: 8] = 8'hFF;
        else f[8*i +: 8] = {1'b1, glyph(int'(rest % 10))};
        rest = rest / 10;
      end
      if (longint'(v) >= 100000000) f[63] = 1'b0;
    end
    return f;
  endfunction

  function automatic logic [31:0] sel_value(input logic [2:0] s);
    case (s)
      3'd0: return led_data_in;
      3'd1: return total_cycles;
      3'd2: return condi_branch_num;
      3'd3: return uncondi_branch_num;
      3'd4: return bubble_num;
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: checks one full scan frame against each queued expectation.
  initial begin
    logic [63:0] e;
    logic [7:0]  prev;
    bit          found;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        found = 0;
        for (int k = 0; k < 100; k++) begin
          prev = an;
          @(negedge clk);
          if (prev != 8'hFE && an == 8'hFE) begin
            found = 1;
            break;
          end
        end
        if (!found) check("frame_start_an", {24'h0, an}, 32'hFE);
        else begin
          for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk);
            check("scan_an", {24'h0, an}, {24'h0, ~(8'b1 << (k / 4))});
            check("digit_seg", {24'h0, seg}, {24'h0, e[8*(k/4) +: 8]});
          end
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // Every completed conversion pass must keep conv_busy high exactly 32 cycles.
  initial begin
    int run;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst) run = 0;
      else if (conv_busy) run++;
      else if (run != 0) begin
        check("busy_len", run, 32);
        run = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  task automatic show();
    repeat (80) @(negedge clk);
    if (hex_mode) check("busy_in_hex", {31'h0, conv_busy}, 0);
    exp_q.push_back(model(sel_value(disp_sel), hex_mode));
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    check("frame_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    logic prev;
    for (int k = 0; k < 100; k++) begin
      prev = conv_busy;
      @(negedge clk);
      if (prev != lvl && conv_busy == lvl) return;
    end
    check(name, {31'h0, conv_busy}, {31'h0, lvl});
  endtask

  initial begin
    logic [63:0] ea;
    rst = 1'b0;
    led_data_in = 0; total_cycles = 0; condi_branch_num = 0;
    uncondi_branch_num = 0; bubble_num = 0; disp_sel = 0; hex_mode = 0;
    repeat (3) @(negedge clk);
    check("reset_seg", {24'h0, seg}, 32'hFF);
    check("reset_an", {24'h0, an}, 32'hFF);
    check("reset_busy", {31'h0, conv_busy}, 0);
    rst = 1'b1;

    hex_mode = 1; disp_sel = 0; led_data_in = 32'h12345678;
    show();
    hex_mode = 0; disp_sel = 1; total_cycles = 1234;
    show();
    hex_mode = 0; disp_sel = 4; bubble_num = 32'hFFFFFFFF;
    show();
    hex_mode = 0; disp_sel = 6;
    show();
    hex_mode = 0; disp_sel = 3; uncondi_branch_num = 100000000;
    show();

    for (int it = 0; it < 10; it++) begin
      hex_mode = 1'($urandom_range(0, 1));
      disp_sel = 3'($urandom_range(0, 7));
      led_data_in        = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 999) : $urandom();
      total_cycles       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99999) : $urandom();
      condi_branch_num   = $urandom();
      uncondi_branch_num = $urandom_range(0, 9);
      bubble_num         = $urandom();
      show();
    end

    // Select change mid-conversion, then reset mid-conversion.
    hex_mode = 0; disp_sel = 6;
    show();
    total_cycles     = $urandom_range(10000000, 99999999);
    condi_branch_num = $urandom_range(10000000, 99999999);
    ea = model(total_cycles, 1'b0);
    disp_sel = 1;
    wait_busy(1'b1, "busy_rise_1");
    repeat (10) @(negedge clk);
    disp_sel = 2;
    wait_busy(1'b0, "busy_fall_1");
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 8; j++) begin
        if (an == ~(8'b1 << j)) check("first_load_src1", {24'h0, seg}, {24'h0, ea[8*j +: 8]});
      end
      @(negedge clk);
    end
    wait_busy(1'b1, "busy_rise_2");
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midconv_reset_busy", {31'h0, conv_busy}, 0);
    check("midconv_reset_seg", {24'h0, seg}, 32'hFF);
    check("midconv_reset_an", {24'h0, an}, 32'hFF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    show();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
